// File: rtl/bcd_time_keeper_pkg.sv
// Mode encodings shared by the time keeper, the control FSM and the display mux.
package bcd_time_keeper_pkg;

  typedef enum logic [2:0] {
    MODE_RUN     = 3'b000,
    MODE_CLK_HR  = 3'b001,
    MODE_CLK_MIN = 3'b010,
    MODE_ALM_HR  = 3'b100,
    MODE_ALM_MIN = 3'b101
  } mode_e;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned UNITS_W = 4;

  // Clock-field adjust modes freeze the running time.
  function automatic logic is_clk_adjust(input logic [MODE_W-1:0] m);
    return (m == MODE_CLK_HR) || (m == MODE_CLK_MIN);
  endfunction

endpackage

// File: rtl/bcd_time_keeper_counter.sv
// Two-digit BCD modulo counter (MOD 60 or 24) with up/down wrap and a look-ahead next value.
module bcd_mod_counter
  import bcd_time_keeper_pkg::*;
#(
  parameter int unsigned MOD    = 60,
  parameter int unsigned TENS_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [UNITS_W-1:0] units,
  output logic [TENS_W-1:0]  tens,
  output logic [UNITS_W-1:0] next_units_c,
  output logic [TENS_W-1:0]  next_tens_c
);

  localparam logic [UNITS_W-1:0] MAX_U = UNITS_W'((MOD - 1) % 10);
  localparam logic [TENS_W-1:0]  MAX_T = TENS_W'((MOD - 1) / 10);

  // Digit-wise increment/decrement; inc and dec together cancel.
  always_comb begin
    next_units_c = units;
    next_tens_c  = tens;
    if (inc && !dec) begin
      if ((tens == MAX_T) && (units == MAX_U)) begin
        next_units_c = '0;
        next_tens_c  = '0;
      end else if (units == UNITS_W'(9)) begin
        next_units_c = '0;
        next_tens_c  = tens + TENS_W'(1);
      end else begin
        next_units_c = units + UNITS_W'(1);
      end
    end else if (dec && !inc) begin
      if ((tens == '0) && (units == '0)) begin
        next_units_c = MAX_U;
        next_tens_c  = MAX_T;
      end else if (units == '0) begin
        next_units_c = UNITS_W'(9);
        next_tens_c  = tens - TENS_W'(1);
      end else begin
        next_units_c = units - UNITS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units <= '0;
      tens  <= '0;
    end else begin
      units <= next_units_c;
      tens  <= next_tens_c;
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD time-of-day and alarm registers with tick advance, mode-driven adjust and alarm match pulse.
module bcd_time_keeper
  import bcd_time_keeper_pkg::*;
#(
  parameter int unsigned SECS_PER_MIN = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_sec,
  input  logic [MODE_W-1:0] state,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              alarm_en,
  output logic [3:0]        minutes_units,
  output logic [2:0]        minutes_tens,
  output logic [3:0]        hours_units,
  output logic [1:0]        hours_tens,
  output logic [3:0]        minutes_units_A,
  output logic [2:0]        minutes_tens_A,
  output logic [3:0]        hours_units_A,
  output logic [2:0]        hours_tens_A,
  output logic              clk_seconds,
  output logic              alarm_match
);

  localparam int unsigned SEC_W = (SECS_PER_MIN > 2) ? $clog2(SECS_PER_MIN) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECS_PER_MIN - 1);

  logic [SEC_W-1:0] sec;
  logic clk_adj_c, adj_c, tick_ok_c, sec_wrap_c, min_carry_c, match_c;
  logic cm_inc_c, cm_dec_c, ch_inc_c, ch_dec_c;
  logic am_inc_c, am_dec_c, ah_inc_c, ah_dec_c;
  logic [3:0] cm_nu_c, ch_nu_c, am_nu_c, ah_nu_c;
  logic [2:0] cm_nt_c, am_nt_c, ah_nt_c;
  logic [1:0] ch_nt_c;

  assign clk_adj_c  = is_clk_adjust(state);
  assign adj_c      = inc_pulse ^ dec_pulse;
  assign tick_ok_c  = tick_sec && !clk_adj_c;
  assign sec_wrap_c = tick_ok_c && (sec == SEC_LAST);

  // Carry from minute 59 into hours only on a running tick, never from a minute adjust.
  assign min_carry_c = sec_wrap_c && (minutes_units == 4'd9) && (minutes_tens == 3'd5);

  assign cm_inc_c = sec_wrap_c || ((state == MODE_CLK_MIN) && inc_pulse);
  assign cm_dec_c = (state == MODE_CLK_MIN) && dec_pulse;
  assign ch_inc_c = min_carry_c || ((state == MODE_CLK_HR) && inc_pulse);
  assign ch_dec_c = (state == MODE_CLK_HR) && dec_pulse;
  assign am_inc_c = (state == MODE_ALM_MIN) && inc_pulse;
  assign am_dec_c = (state == MODE_ALM_MIN) && dec_pulse;
  assign ah_inc_c = (state == MODE_ALM_HR) && inc_pulse;
  assign ah_dec_c = (state == MODE_ALM_HR) && dec_pulse;

  bcd_mod_counter #(.MOD(60), .TENS_W(3)) u_clk_min (
    .clk(clk), .rst(rst), .inc(cm_inc_c), .dec(cm_dec_c),
    .units(minutes_units), .tens(minutes_tens),
    .next_units_c(cm_nu_c), .next_tens_c(cm_nt_c)
  );

  bcd_mod_counter #(.MOD(24), .TENS_W(2)) u_clk_hr (
    .clk(clk), .rst(rst), .inc(ch_inc_c), .dec(ch_dec_c),
    .units(hours_units), .tens(hours_tens),
    .next_units_c(ch_nu_c), .next_tens_c(ch_nt_c)
  );

  bcd_mod_counter #(.MOD(60), .TENS_W(3)) u_alm_min (
    .clk(clk), .rst(rst), .inc(am_inc_c), .dec(am_dec_c),
    .units(minutes_units_A), .tens(minutes_tens_A),
    .next_units_c(am_nu_c), .next_tens_c(am_nt_c)
  );

  bcd_mod_counter #(.MOD(24), .TENS_W(3)) u_alm_hr (
    .clk(clk), .rst(rst), .inc(ah_inc_c), .dec(ah_dec_c),
    .units(hours_units_A), .tens(hours_tens_A),
    .next_units_c(ah_nu_c), .next_tens_c(ah_nt_c)
  );

  // Compare post-edge values so the pulse lines up with the displayed rollover.
  assign match_c = alarm_en && sec_wrap_c &&
                   (cm_nu_c == am_nu_c) && (cm_nt_c == am_nt_c) &&
                   (ch_nu_c == ah_nu_c) && ({1'b0, ch_nt_c} == ah_nt_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec         <= '0;
      clk_seconds <= 1'b0;
      alarm_match <= 1'b0;
    end else begin
      alarm_match <= match_c;
      if (tick_ok_c) clk_seconds <= ~clk_seconds;
      if (clk_adj_c && adj_c) begin
        sec <= '0;
      end else if (tick_ok_c) begin
        sec <= sec_wrap_c ? '0 : sec + SEC_W'(1);
      end
    end
  end

endmodule
